cmn_lfsr_arb: RTL

- Pseudo-random N-way arbiter that shares one downstream resource among REQ_NUM requesters.
- Start priority comes from an internal 4-bit maximal-length LFSR (x^4+x+1, shift-left Fibonacci, seed 4'b0001). The LFSR advances only on accepted grants.
- Per-requester starvation counters force a deterministic grant when any requester waits too long.
- Sits between request sources (e.g. issue/replay queues) and a shared port.

---
 rtl/cmn_lfsr_arb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cmn_lfsr_arb.sv
// rtl/cmn_lfsr_arb.sv - pseudo-random N-way arbiter with LFSR start priority and starvation override
module cmn_lfsr_arb #(
    parameter int REQ_NUM    = 4,
    parameter int IDX_W      = $clog2(REQ_NUM),
    parameter int STARVE_MAX = 15,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQ_NUM-1:0] req_vld,
    output logic [REQ_NUM-1:0] req_rdy,
    output logic               out_vld,
    output logic [IDX_W-1:0]   out_id,
    output logic               out_starved,
    input  logic               out_rdy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q [REQ_NUM];
    logic               hs;
    logic [REQ_NUM-1:0] id_onehot;
    logic [REQ_NUM-1:0] elig;
    logic [IDX_W-1:0]   start;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   win_id;
    logic               win_starved;
    logic               found;
    logic               vld_d;
    logic [IDX_W-1:0]   id_d;
    logic               starved_d;

    assign hs        = out_vld & out_rdy;
    assign id_onehot = REQ_NUM'(1) << out_id;
    assign req_rdy   = hs ? id_onehot : '0;
    assign lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[0]};

    // The requester just served sits out the cycle of its handshake.
    always_comb begin
        elig = '0;
        if (state_q == IDLE)
            elig = req_vld;
        else if (hs)
            elig = req_vld & ~id_onehot;
    end

    assign start = hs ? lfsr_d[IDX_W-1:0] : lfsr_q[IDX_W-1:0];

    // Starved requesters preempt the rotating search; lowest index wins among them.
    always_comb begin
        win_id      = '0;
        win_starved = 1'b0;
        found       = 1'b0;
        idx         = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (elig[i] && (cnt_q[i] >= CNT_W'(STARVE_MAX))) begin
                win_id      = IDX_W'(i);
                win_starved = 1'b1;
            end
        end
        if (!win_starved) begin
            for (int k = 0; k < REQ_NUM; k++) begin
                idx = start + IDX_W'(k);
                if (!found && elig[idx]) begin
                    win_id = idx;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        vld_d     = out_vld;
        id_d      = out_id;
        starved_d = out_starved;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d   = GRANT;
                    vld_d     = 1'b1;
                    id_d      = win_id;
                    starved_d = win_starved;
                end
            end
            GRANT: begin
                if (hs) begin
                    if (|elig) begin
                        id_d      = win_id;
                        starved_d = win_starved;
                    end else begin
                        state_d   = IDLE;
                        vld_d     = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_vld     <= 1'b0;
            out_id      <= '0;
            out_starved <= 1'b0;
            lfsr_q      <= 4'b0001;
        end else begin
            state_q     <= state_d;
            out_vld     <= vld_d;
            out_id      <= id_d;
            out_starved <= starved_d;
            if (hs)
                lfsr_q <= lfsr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REQ_NUM; i++)
                cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < REQ_NUM; i++) begin
                if (req_rdy[i] || !req_vld[i])
                    cnt_q[i] <= '0;
                else if (!(out_vld && (out_id == IDX_W'(i))) && (cnt_q[i] < CNT_W'(STARVE_MAX)))
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

endmodule
